fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Holds the program counter and issues word requests to instruction memory.
- Buffers returned words with their PCs in a small in-order queue, and presents them to decode over a valid/ready handshake.
- Applies branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, >= 2; also the bound on queued + in-flight words.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  word address of request (bits [1:0] = 0 in normal operation)
- imem_resp_valid  input  1  response data valid; in-order, never earlier than the cycle after acceptance, no backpressure
- imem_resp_data  input  32  instruction word
- redirect_valid  input  1  PC redirect from execute (branch/jump taken)
- redirect_pc  input  32  redirect target
- instr_valid  output  1  queue head valid toward decoder
- instr_ready  input  1  decoder consumes head
- instruction  output  32  queue head word (feeds decoder instruction input)
- instr_pc  output  32  PC of queue head
- misalign_fault  output  1  only with FETCH_MISALIGN_CHECK_EN

Behaviour:
- Reset (reset_n low at a clock edge):
  - fetch_pc = RESET_PC; state = BOOT.
  - Queue empty; outstanding = 0; drop = 0.
  - Outputs: imem_req_valid = 0, imem_req_addr = RESET_PC, instr_valid = 0, instruction = 32'h0000_0013 (NOP), instr_pc = 0, misalign_fault = 0.
  - Reset mid-operation discards everything; responses arriving while reset_n is low are ignored.
- FSM:
  - BOOT: one idle cycle, then RUN.
  - RUN: normal fetch.
  - DRAIN: discarding stale responses; no requests issued; go to RUN in the cycle drop reaches 0.
- Request and credit:
  - imem_req_addr = fetch_pc (combinational from register).
  - imem_req_valid = (state == RUN) && !redirect_valid && (occupancy + outstanding < QUEUE_DEPTH).
  - On a request handshake: fetch_pc += 4 (wraps mod 2^32); outstanding += 1.
- Response:
  - Every imem_resp_valid decrements outstanding.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise push {imem_resp_data, pc} into the queue. pc comes from an internal in-flight PC FIFO, or equivalently a resp_pc register that increments by 4 per accepted response.
  - Credit rule guarantees no overflow; simultaneous push and pop at full is legal.
- Decoder side:
  - instr_valid = !empty.
  - Head pops when instr_valid && instr_ready.
  - Push to an empty queue is visible the next cycle; 1-cycle memory gives 2-cycle request-to-instr_valid latency.
  - instruction/instr_pc hold stable while instr_valid && !instr_ready.
- Redirect (highest priority):
  - Next cycle: fetch_pc = redirect_pc; queue cleared (a same-cycle pop or push is discarded).
  - drop = outstanding after this cycle's response decrement.
  - state = DRAIN if that value > 0, else RUN.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
  - Redirect during BOOT: takes effect; BOOT is still exited after one cycle.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - redirect_pc[1:0] != 0 sets misalign_fault = 1 (sticky until reset); fetch_pc is loaded with the target.
  - State enters a HALT state: no requests, queue empty, instr_valid = 0.
- Undefined:
  - Port absent.
  - redirect_pc[1:0] is forced to 0 when loaded.

Test Plan:
- Reset release, 1-cycle memory, instr_ready = 1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles after BOOT; instr_valid first high 2 cycles after first request with instr_pc = 0x0.
- instr_ready = 0 for 10 cycles -> exactly QUEUE_DEPTH (2) words queued; imem_req_valid low; head stays 0x0 / data unchanged.
- Redirect to 0x100 with 2 responses in flight (3-cycle memory) -> both stale words dropped; next instr_pc = 0x100; state passes through DRAIN.
- Redirect in same cycle as a pop and a response -> queue empty next cycle; response discarded; fetch resumes at target.
- fetch_pc = 0xFFFF_FFFC -> next request address 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc = 0x102 -> misalign_fault = 1 next cycle; no further imem_req_valid until reset.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input, decode port.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instruction,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instruction,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited requests, in-order queue, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect raises sticky fault and halts.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic misalign_fault,
`endif
  fetch_unit_if.master bus
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(QUEUE_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN,
    HALT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;

  logic [31:0] data_mem [QUEUE_DEPTH];
  logic [31:0] pc_mem   [QUEUE_DEPTH];

  logic        req_fire;
  logic        pop;
  logic        push;
  logic        flush;
  logic        redir;
  logic        bad_tgt;
  logic [31:0] tgt;
  logic [CW:0] used;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign tgt            = bus.redirect_pc;
  assign bad_tgt        = |bus.redirect_pc[1:0];
  assign misalign_fault = fault_q;
`else
  assign tgt     = bus.redirect_pc & ~32'h3;
  assign bad_tgt = 1'b0;
`endif

  assign used  = {1'b0, cnt_q} + {1'b0, out_q};
  assign redir = bus.redirect_valid && (state_q != HALT);

  always_comb begin
    bus.imem_req_addr  = fetch_pc_q;
    bus.imem_req_valid = (state_q == RUN) && !bus.redirect_valid
                         && (used < LIMIT);
    bus.instr_valid    = (cnt_q != '0);
    bus.instruction    = bus.instr_valid ? data_mem[rd_q] : NOP;
    bus.instr_pc       = bus.instr_valid ? pc_mem[rd_q] : 32'h0;
  end

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign pop      = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    flush      = 1'b0;
    push       = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d    = fault_q;
`endif

    out_d = out_q + CW'(req_fire) - CW'(bus.imem_resp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (bus.imem_resp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end else if (state_q != HALT) begin
        push = 1'b1;
      end
    end

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      HALT:    flush = 1'b1;
      default: state_d = BOOT;
    endcase

    // Redirect overrides everything; words still in flight become stale.
    if (redir) begin
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      drop_d     = out_d;
      flush      = 1'b1;
      push       = 1'b0;
      state_d    = (out_d != '0) ? DRAIN : RUN;
      if (bad_tgt) begin
        state_d = HALT;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d = fault_q | bad_tgt;
`endif
    end

    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
    end
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      data_mem[wr_q] <= bus.imem_resp_data;
      pc_mem[wr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with variable latency,
// expected words queued at request acceptance and compared at the decode port.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mf;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_fault (mf),
`endif
    .bus            (bus)
  );

`ifndef FETCH_MISALIGN_CHECK_EN
  assign mf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } fl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d;
  } ex_t;

  fl_t infl[$];
  ex_t exq[$];
  logic [31:0] acc_log[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_acc = 0;
  int lat = 1;
  int acc_cyc = -1;
  int v_cyc = -1;
  int stale_n = 0;
  logic rdy = 1'b1;
  logic in_rst = 1'b1;
  logic redir_en = 1'b0;
  logic arm = 1'b0;
  logic armed_fired = 1'b0;
  logic resp_now = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] last_acc = '0;
  logic [31:0] first_addr = '1;
  logic [31:0] nxt_pc = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    logic r;
    @(negedge clk);
    cyc++;
    reset_n = !in_rst;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready = rdy;
    resp_now = 1'b0;
    if (in_rst) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data = 32'hDEAD_BEEF;
      infl.delete();
      exq.delete();
      nxt_pc = 32'h0;
    end else if (infl.size() > 0 && infl[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data = memf(infl[0].addr);
      void'(infl.pop_front());
      resp_now = 1'b1;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = 32'h0;
    end
    r = !in_rst && (redir_en || (arm && resp_now && bus.instr_valid));
    if (r && !redir_en) begin
      arm = 1'b0;
      armed_fired = 1'b1;
    end
    bus.redirect_valid = r;
    bus.redirect_pc = redir_tgt;
    #1;
    if (in_rst) return;
    if (bus.instr_valid) begin
      if (v_cyc < 0) v_cyc = cyc;
      if (exq.size() == 0) begin
        chk("spurious_valid", bus.instr_valid, 0);
      end else begin
        chk("head_pc", bus.instr_pc, exq[0].pc);
        chk("head_data", bus.instruction, exq[0].d);
        if (rdy) void'(exq.pop_front());
      end
    end
    if (r) begin
      chk("redir_noreq", bus.imem_req_valid, 0);
      exq.delete();
      stale_n = infl.size();
`ifdef FETCH_MISALIGN_CHECK_EN
      nxt_pc = redir_tgt;
`else
      nxt_pc = redir_tgt & ~32'h3;
`endif
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, nxt_pc);
      nxt_pc = nxt_pc + 32'd4;
      if (acc_cyc < 0) begin
        acc_cyc = cyc;
        first_addr = bus.imem_req_addr;
      end
      infl.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      exq.push_back('{pc: bus.imem_req_addr, d: memf(bus.imem_req_addr)});
      acc_log.push_back(bus.imem_req_addr);
      last_acc = bus.imem_req_addr;
      n_acc++;
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instruction", bus.instruction, 32'h0000_0013);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_fault", mf, 0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    step();
    while (!bus.instr_valid && k < 30) begin
      step();
      k++;
    end
    chk(tag, bus.instr_valid, 1);
  endtask

  initial begin
    int rel, n0, cnt, k, sn;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;

    repeat (3) step();
    chk_reset();

    in_rst = 1'b0;
    step();
    rel = cyc;
    chk("boot_idle", bus.imem_req_valid, 0);
    k = 0;
    while (acc_cyc < 0 && k < 10) begin
      step();
      k++;
    end
    chk("first_req_cyc", acc_cyc - rel, 1);
    chk("first_addr", first_addr, 32'h0);
    k = 0;
    while (v_cyc < 0 && k < 10) begin
      step();
      k++;
    end
    chk("fill_latency", v_cyc - acc_cyc, 2);
    repeat (12) step();

    rdy = 1'b0;
    repeat (10) step();
    chk("stall_qcnt", exq.size(), 2);
    chk("stall_noreq", bus.imem_req_valid, 0);
    rdy = 1'b1;
    repeat (6) step();

    lat = 3;
    k = 0;
    step();
    while (infl.size() != 2 && k < 30) begin
      step();
      k++;
    end
    redir_tgt = 32'h100;
    redir_en = 1'b1;
    step();
    redir_en = 1'b0;
    sn = stale_n;
    cnt = 0;
    n0 = n_acc;
    k = 0;
    while (n_acc == n0 && k < 20) begin
      step();
      if (resp_now) cnt++;
      k++;
    end
    chk("stale_nz", sn != 0, 1);
    chk("drain_drops", cnt, sn);
    chk("redir_addr", last_acc, 32'h100);
    wait_valid("redir_valid");
    chk("redir_pc", bus.instr_pc, 32'h100);
    repeat (8) step();

    lat = 1;
    repeat (6) step();
    redir_tgt = 32'h200;
    arm = 1'b1;
    k = 0;
    while (!armed_fired && k < 20) begin
      step();
      k++;
    end
    arm = 1'b0;
    chk("arm_fired", armed_fired, 1);
    step();
    chk("flush_empty", bus.instr_valid, 0);
    wait_valid("redir2_valid");
    chk("redir2_pc", bus.instr_pc, 32'h200);
    repeat (4) step();

    acc_log.delete();
    redir_tgt = 32'hFFFF_FFF8;
    redir_en = 1'b1;
    step();
    redir_en = 1'b0;
    k = 0;
    while (acc_log.size() < 4 && k < 30) begin
      step();
      k++;
    end
    chk("wrap_cnt", acc_log.size() >= 4, 1);
    if (acc_log.size() >= 4) begin
      chk("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", acc_log[2], 32'h0);
      chk("wrap_a3", acc_log[3], 32'h4);
    end
    repeat (6) step();

    redir_tgt = 32'h102;
    redir_en = 1'b1;
    step();
    redir_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    step();
    chk("misalign_fault", mf, 1);
    repeat (8) begin
      step();
      chk("halt_noreq", bus.imem_req_valid, 0);
      chk("halt_novalid", bus.instr_valid, 0);
    end
    chk("fault_sticky", mf, 1);
`else
    n0 = n_acc;
    k = 0;
    while (n_acc == n0 && k < 20) begin
      step();
      k++;
    end
    chk("mask_addr", last_acc, 32'h100);
    wait_valid("mask_valid");
    chk("mask_pc", bus.instr_pc, 32'h100);
`endif

    in_rst = 1'b1;
    repeat (3) step();
    chk_reset();
    in_rst = 1'b0;
    wait_valid("post_rst_valid");
    chk("post_rst_pc", bus.instr_pc, 32'h0);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
